// File: rtl/hit_window_counter.sv
// Counts detection pulses over fixed windows of WIN_LEN enabled cycles and hands each total
// to a consumer through a one-entry valid/ready output register. Optional alarm: HIT_ALARM_EN.
module hit_window_counter #(
  parameter int WIN_LEN = 64,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit,
  input  logic             en,
  input  logic             cnt_ready,
  output logic             cnt_valid,
  output logic [CNT_W-1:0] cnt_data,
  output logic             drop,
`ifdef HIT_ALARM_EN
  input  logic [CNT_W-1:0] threshold,
  output logic             alarm,
`endif
  output logic             dbg_state
);

  // Handshake: a result transfers on a rising edge where cnt_valid & cnt_ready; cnt_data is
  // stable while cnt_valid is high and cnt_ready is ignored while cnt_valid is low.

  localparam int WCNT_W = $clog2(WIN_LEN);
  localparam logic [WCNT_W-1:0] LAST_POS = WCNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0]  ACC_MAX  = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WCNT_W-1:0] r_wcnt;
  logic [WCNT_W-1:0] w_wcnt_next;
  logic [CNT_W-1:0]  r_acc;
  logic [CNT_W-1:0]  w_acc_next;
  logic [CNT_W:0]    w_sum;
  logic [CNT_W-1:0]  w_final;
  logic              w_close;
  logic              w_load;
  logic              w_drop_next;
  logic              r_valid;
  logic [CNT_W-1:0]  r_data;
  logic              r_drop;

  // The live en decides whether this cycle counts, so a window is exactly WIN_LEN en=1 cycles.
  always_comb begin
    w_state_next = en ? COUNT : IDLE;
    w_sum        = {1'b0, r_acc} + {{CNT_W{1'b0}}, hit};
    w_final      = w_sum[CNT_W] ? ACC_MAX : w_sum[CNT_W-1:0];
    w_close      = 1'b0;
    w_wcnt_next  = '0;
    w_acc_next   = '0;
    if (w_state_next == COUNT) begin
      if (r_wcnt == LAST_POS) begin
        w_close = 1'b1;
      end else begin
        w_wcnt_next = r_wcnt + 1'b1;
        w_acc_next  = w_final;
      end
    end
    w_load      = w_close && (!r_valid || cnt_ready);
    w_drop_next = w_close && r_valid && !cnt_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_next;
      r_wcnt  <= w_wcnt_next;
      r_acc   <= w_acc_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= w_drop_next;
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_final;
      end else if (r_valid && cnt_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef HIT_ALARM_EN
  logic r_alarm;
  logic w_alarm_next;

  assign w_alarm_next = w_load && (threshold != '0) && (w_final >= threshold);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alarm <= 1'b0;
    end else begin
      r_alarm <= w_alarm_next;
    end
  end

  assign alarm = r_alarm;
`endif

  assign cnt_valid = r_valid;
  assign cnt_data  = r_data;
  assign drop      = r_drop;
  assign dbg_state = r_state;

endmodule

// File: doc/hit_window_counter.md
# hit_window_counter

Downstream consumer of the 1011 sequence detector's registered `out` pulse. Counts detection pulses over fixed windows of `WIN_LEN` clock cycles and reports each window's total to a consumer through a valid/ready handshake with a one-entry output register. If the previous result is still unconsumed, the new result is dropped and flagged.

## Interface
- `WIN_LEN`, 64: cycles per counting window; legal range ≥ 2.
- `CNT_W`, 8: width of the accumulator and of the reported count.

- `clk`  in  1  sole clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `hit`  in  1  detection pulse from the sequence detector; sampled every cycle.
- `en`  in  1  window enable; low aborts and clears the window in progress.
- `cnt_ready`  in  1  consumer accepts `cnt_data` when high with `cnt_valid`.
- `cnt_valid`  out  1  `cnt_data` holds an unconsumed window result.
- `cnt_data`  out  CNT_W  hit count of the last completed window.
- `drop`  out  1  one-cycle pulse: a completed window result was discarded.
- `threshold`  in  CNT_W  alarm threshold (only with `HIT_ALARM_EN`).
- `alarm`  out  1  one-cycle alarm pulse (only with `HIT_ALARM_EN`).

## Operation
- FSM states:
  - IDLE: `en`=0.
  - COUNT: `en`=1.
  - IDLE→COUNT on `en`=1; COUNT→IDLE on `en`=0.
- Counters:
  - `wcnt` is the window position, width `$clog2(WIN_LEN)`.
  - `acc` is the running count, `CNT_W` bits.
- In IDLE, `wcnt` and `acc` are held at 0. `hit` is ignored, including in the cycle `en` is sampled low.
- In COUNT with `wcnt < WIN_LEN-1`:
  - `wcnt` increments.
  - `acc` increments when `hit`=1 and saturates at 2^CNT_W−1.
- Window close is the COUNT cycle with `wcnt == WIN_LEN-1`:
  - final = `acc` + `hit`, saturating.
  - `wcnt` and `acc` reset to 0 and the next window starts immediately, with no gap cycle.
- Output register load at close:
  - Load occurs if `cnt_valid`=0, or if `cnt_valid`=1 and `cnt_ready`=1 in the same cycle.
  - On load: `cnt_data` ← final and `cnt_valid` ← 1.
  - Otherwise the result is discarded: `drop` pulses, and `cnt_data`/`cnt_valid` are unchanged.
- Handshake:
  - `cnt_valid` falls on the edge where `cnt_valid & cnt_ready` and no new load occurs.
  - `cnt_data` is stable while `cnt_valid`=1.
  - `cnt_ready` has no effect when `cnt_valid`=0.
- Deasserting `en` does not touch the output register. A pending result remains available.

## Timing
- Reset values, applied asynchronously on `rst`=0:
  - `cnt_valid`=0, `cnt_data`=0, `drop`=0, `alarm`=0.
  - `wcnt`=0, `acc`=0, state IDLE.
- Release is synchronous in effect: the first COUNT cycle is the first edge after `rst`=1 with `en`=1.
- Window length is exactly `WIN_LEN` consecutive `en`=1 cycles. A `hit` in every one of those cycles is counted.
- Latency: `cnt_valid`/`cnt_data` update on the edge that ends the close cycle, i.e. the close cycle + 1. `drop` asserts on that same edge for one cycle.
- Reset mid-window discards the partial count and any pending result.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `HIT_ALARM_EN`.
- Defined:
  - Ports `threshold` and `alarm` exist.
  - `alarm` pulses for one cycle on the edge a result is loaded, when `threshold` != 0 and final ≥ `threshold`.
  - `threshold` is sampled in the close cycle.
  - Dropped results never raise `alarm`.
- Undefined: both ports and all alarm logic are absent. All other behaviour is identical.

## Test plan
All scenarios use `WIN_LEN`=8 and `CNT_W`=4 unless noted.
- Normal count and alarm:
  - Stimulus: `en`=1, `cnt_ready`=1, `hit` at window cycles 0, 3 and 7; with `HIT_ALARM_EN` and `threshold`=3.
  - Required: `cnt_valid`=1 for one cycle at close+1 with `cnt_data`=3, and `alarm`=1 in the same cycle.
  - Repeat with `threshold`=4: `alarm` stays 0.
- Saturation:
  - Stimulus: `CNT_W`=2, `hit`=1 for all 8 cycles.
  - Required: `cnt_data`=3, `drop`=0.
- Backpressure drop:
  - Stimulus: `cnt_ready`=0 for two full windows with counts 2 then 5.
  - Required: `cnt_data` stays 2 and `cnt_valid` stays 1. `drop` pulses once at the second close+1.
  - Then `cnt_ready`=1: `cnt_valid` falls on the next edge.
- Simultaneous consume and close:
  - Stimulus: `cnt_valid`=1 and `cnt_ready`=1 in the close cycle of a window with count 4.
  - Required: `cnt_data`=4, `cnt_valid` remains 1, `drop`=0.
- Enable abort:
  - Stimulus: 2 hits in cycles 0–3, `en`=0 at cycle 4, then `en`=1 with 1 hit over the next 8 cycles.
  - Required: reported `cnt_data`=1, and no result is produced for the aborted window.
- Asynchronous reset:
  - Stimulus: `rst`=0 mid-window while `cnt_valid`=1.
  - Required: all outputs are 0 immediately, without waiting for a clock edge. After release, the next full window reports only its own hits.
